cpu_clk_ctrl: RTL and testbench

//  Run/halt/single-step controller for the CPU clock enable. Divides i_clk by a runtime-programmable N.

---
 rtl/cpu_clk_ctrl.sv | 133 +++++++++++++
 tb/tb_cpu_clk_ctrl.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_clk_ctrl.sv
// CPU clock-enable controller: divides i_clk by a programmable N and gates the
// resulting one-cycle enable pulses for debugger run / halt / single-step.
module cpu_clk_ctrl #(
  parameter int DIV_W        = 8,
  parameter int DEFAULT_DIV  = 2,
  parameter bit RESET_HALTED = 1'b0
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_div_valid,
  input  logic [DIV_W-1:0] i_div,
  output logic             o_div_ready,
  input  logic             i_halt_req,
  input  logic             i_step,
  output logic             o_halted,
  output logic             o_clk_en,
  output logic [31:0]      o_cycle_cnt
);

  localparam logic [DIV_W-1:0] RST_DIV = (DEFAULT_DIV == 0) ? DIV_W'(1) : DIV_W'(DEFAULT_DIV);

  typedef enum logic [1:0] {
    S_RUN     = 2'd0,
    S_HALTING = 2'd1,
    S_HALTED  = 2'd2,
    S_STEP    = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] pend_div_q;
  logic             pend_vld_q, pend_vld_d;
  logic             cut_q, cut_d;
  logic [31:0]      cycle_cnt_q;
  logic             eop, accept, apply;

  function automatic logic [DIV_W-1:0] clamp_div(input logic [DIV_W-1:0] d);
    return (d == '0) ? DIV_W'(1) : d;
  endfunction

  assign eop    = (cnt_q == div_q - DIV_W'(1));
  assign accept = i_div_valid && !pend_vld_q;
  assign apply  = pend_vld_q && (eop || state_q == S_HALTED);

  assign o_clk_en    = eop && (state_q == S_RUN || state_q == S_STEP) && !cut_q;
  assign o_halted    = (state_q == S_HALTED);
  assign o_div_ready = !pend_vld_q;
  assign o_cycle_cnt = cycle_cnt_q;

  // cut_q marks a period whose pulse was revoked by a halt request; it stays
  // set even if the request is withdrawn, so that period ends silently.
  always_comb begin
    state_d    = state_q;
    cut_d      = cut_q;
    cnt_d      = eop ? '0 : cnt_q + DIV_W'(1);
    pend_vld_d = pend_vld_q;
    div_d      = div_q;
    case (state_q)
      S_RUN: begin
        if (i_halt_req) begin
          state_d = S_HALTING;
          cut_d   = 1'b1;
        end else if (eop) begin
          cut_d = 1'b0;
        end
      end
      S_HALTING: begin
        if (eop) begin
          state_d = S_HALTED;
          cut_d   = 1'b0;
        end else if (!i_halt_req) begin
          state_d = S_RUN;
        end
      end
      S_HALTED: begin
        cnt_d = '0;
        cut_d = 1'b0;
        if (i_step) begin
          state_d = S_STEP;
        end else if (!i_halt_req) begin
          state_d = S_RUN;
        end
      end
      S_STEP: begin
        if (eop) begin
          state_d = S_HALTED;
        end
      end
      default: state_d = S_RUN;
    endcase
    if (apply) begin
      div_d      = clamp_div(pend_div_q);
      cnt_d      = '0;
      pend_vld_d = 1'b0;
    end
    if (accept) begin
      pend_vld_d = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= RESET_HALTED ? S_HALTED : S_RUN;
      cnt_q      <= '0;
      div_q      <= RST_DIV;
      pend_vld_q <= 1'b0;
      cut_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      div_q      <= div_d;
      pend_vld_q <= pend_vld_d;
      cut_q      <= cut_d;
    end
  end

  // Pending divisor value is data only; its valid flag above carries the reset.
  always_ff @(posedge i_clk) begin
    if (accept) begin
      pend_div_q <= i_div;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cycle_cnt_q <= '0;
    end else if (o_clk_en) begin
      cycle_cnt_q <= cycle_cnt_q + 32'd1;
    end
  end

endmodule

// File: tb/tb_cpu_clk_ctrl.sv
// Scoreboard bench for cpu_clk_ctrl: a behavioural model predicts every cycle's
// outputs into a queue; an independent monitor pops and compares them.
module tb_cpu_clk_ctrl;

  localparam int DIV_W       = 8;
  localparam int DEFAULT_DIV = 2;

  logic             clk = 1'b0;
  logic             rst, div_valid, halt_req, step;
  logic [DIV_W-1:0] div;
  logic             div_ready, halted, clk_en;
  logic [31:0]      cycle_cnt;

  cpu_clk_ctrl #(.DIV_W(DIV_W), .DEFAULT_DIV(DEFAULT_DIV), .RESET_HALTED(1'b0)) dut (
    .i_clk(clk), .i_rst(rst), .i_div_valid(div_valid), .i_div(div),
    .o_div_ready(div_ready), .i_halt_req(halt_req), .i_step(step),
    .o_halted(halted), .o_clk_en(clk_en), .o_cycle_cnt(cycle_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic        hlt;
    logic        rdy;
    logic [31:0] cc;
    int          n;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   ncyc  = 0;

  // Model: position within the current period, its length, and what the
  // controller is doing (stopped, single-stepping, draining toward a halt).
  int          m_len, m_pos, m_new_len;
  bit          m_stop, m_stepg, m_drain, m_cut, m_has_new;
  logic [31:0] m_pulses;

  function automatic void m_reset();
    m_len     = (DEFAULT_DIV == 0) ? 1 : DEFAULT_DIV;
    m_pos     = 0;
    m_new_len = 1;
    m_stop    = 1'b0;
    m_stepg   = 1'b0;
    m_drain   = 1'b0;
    m_cut     = 1'b0;
    m_has_new = 1'b0;
    m_pulses  = '0;
  endfunction

  function automatic bit m_end();
    return (m_pos == m_len - 1);
  endfunction

  function automatic bit m_pulse();
    return m_end() && !m_stop && !m_cut;
  endfunction

  function automatic void m_advance(bit r, bit h, bit s, bit v, logic [DIV_W-1:0] d);
    bit end_now, accept, apply;
    end_now = m_end();
    if (r) begin
      m_reset();
      return;
    end
    if (m_pulse()) m_pulses = m_pulses + 32'd1;
    accept = v && !m_has_new;
    apply  = m_has_new && (m_stop || end_now);
    if (apply) begin
      m_len     = m_new_len;
      m_has_new = 1'b0;
    end
    if (accept) begin
      m_new_len = (d == 0) ? 1 : int'(d);
      m_has_new = 1'b1;
    end
    if (m_stop) begin
      m_pos = 0;
      m_cut = 1'b0;
      if (s) begin
        m_stop  = 1'b0;
        m_stepg = 1'b1;
      end else if (!h) begin
        m_stop = 1'b0;
      end
    end else begin
      m_pos = end_now ? 0 : m_pos + 1;
      if (m_stepg) begin
        if (end_now) begin
          m_stepg = 1'b0;
          m_stop  = 1'b1;
        end
      end else if (m_drain) begin
        if (end_now) begin
          m_drain = 1'b0;
          m_stop  = 1'b1;
          m_cut   = 1'b0;
        end else if (!h) begin
          m_drain = 1'b0;
        end
      end else begin
        if (h) begin
          m_drain = 1'b1;
          m_cut   = 1'b1;
        end else if (end_now) begin
          m_cut = 1'b0;
        end
      end
    end
  endfunction

  // Called just after a clock edge: predict the outputs now visible, then
  // drive the next inputs and advance the model across the coming edge.
  task automatic cyc(input bit r, input bit h, input bit s, input bit v, input logic [DIV_W-1:0] d);
    exp_t e;
    e.en  = m_pulse();
    e.hlt = m_stop;
    e.rdy = !m_has_new;
    e.cc  = m_pulses;
    e.n   = ncyc;
    exp_q.push_back(e);
    rst = r; halt_req = h; step = s; div_valid = v; div = d;
    m_advance(r, h, s, v, d);
    ncyc++;
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n, input bit h);
    for (int i = 0; i < n; i++) cyc(1'b0, h, 1'b0, 1'b0, '0);
  endtask

  task automatic chk(input string name, input int n, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s cycle=%0d got=0x%0h want=0x%0h", name, n, got, want);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("clk_en",    e.n, 32'(clk_en),    32'(e.en));
        chk("halted",    e.n, 32'(halted),    32'(e.hlt));
        chk("div_ready", e.n, 32'(div_ready), 32'(e.rdy));
        chk("cycle_cnt", e.n, cycle_cnt,      e.cc);
      end
    end
  end

  initial begin : stim
    bit h_lvl;
    rst = 1'b1; halt_req = 1'b0; step = 1'b0; div_valid = 1'b0; div = '0;
    repeat (2) @(posedge clk);
    #2;
    m_reset();

    // Default divisor, free running.
    idle(12, 1'b0);
    // New divisor offered mid-period, then held valid while not ready.
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 8'd5);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 8'd7);
    idle(14, 1'b0);
    // Divisor 4, then a halt request arriving partway through a period.
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 8'd4);
    idle(9, 1'b0);
    idle(10, 1'b1);
    // Withdrawn halt: request for two cycles then release, then re-halt.
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 8'd6);
    idle(8, 1'b0);
    idle(2, 1'b1);
    idle(10, 1'b0);
    idle(10, 1'b1);
    // Halted: load divisor 3, then single-step.
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 8'd3);
    idle(2, 1'b1);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, '0);
    idle(6, 1'b1);
    // Preload the pulse counter near its top, divisor 0, run through the wrap.
    force dut.cycle_cnt_q = 32'hFFFF_FFFA;
    #1;
    release dut.cycle_cnt_q;
    m_pulses = 32'hFFFF_FFFA;
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 8'd0);
    idle(12, 1'b0);
    // Reset while stepping with a divisor pending.
    idle(4, 1'b1);
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 8'd6);
    idle(2, 1'b1);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, '0);
    idle(2, 1'b1);
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 8'd3);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, '0);
    idle(10, 1'b0);

    // Randomised run.
    h_lvl = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0) h_lvl = !h_lvl;
      cyc(($urandom_range(0, 399) == 0), h_lvl, ($urandom_range(0, 7) == 0),
          ($urandom_range(0, 3) == 0), DIV_W'($urandom_range(0, 6)));
    end
    idle(3, 1'b0);

    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain left=%0d want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
